// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard/control unit.
// Stage records carry register addresses at the widest supported width, zero-extended.
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_WB = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam int BRANCH_E = 2;
    localparam int BRANCH_M = 3;
    localparam int REC_AW   = 8;

    typedef struct packed {
        logic              valid;
        logic [REC_AW-1:0] rs;
        logic [REC_AW-1:0] rt;
        logic [REC_AW-1:0] rd;
        logic              regwrite;
        logic              memtoreg;
    } stage_rec_t;

    localparam stage_rec_t EMPTY_REC = '0;

    // regwrite is already cleared for rd == 0, so register 0 never matches here.
    function automatic logic produces(stage_rec_t r, logic [REC_AW-1:0] addr);
        return r.valid && r.regwrite && (r.rd == addr);
    endfunction

    function automatic logic feeds_decode(stage_rec_t r,
                                          logic [REC_AW-1:0] rs, logic [REC_AW-1:0] rt,
                                          logic uses_rs, logic uses_rt);
        return (uses_rs && produces(r, rs)) || (uses_rt && produces(r, rt));
    endfunction

    function automatic fwd_sel_t pick_fwd(stage_rec_t m, stage_rec_t w, logic [REC_AW-1:0] src);
        if (produces(m, src))
            return FWD_M;
        else if (produces(w, src))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and stall/flush control for the 5-stage MIPS core.
// Tracks E/M/W destination records; stall and flush decisions are purely combinational.
module pipe_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int BRANCH_STAGE = 3,
    parameter int FORWARD_EN   = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rt,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rt,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_regwrite,
    input  logic              dec_memtoreg,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic [1:0]        fwd_a_E,
    output logic [1:0]        fwd_b_E,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    if (!(BRANCH_STAGE == BRANCH_E || BRANCH_STAGE == BRANCH_M)) begin : g_bad_branch_stage
        $error("pipe_hazard_ctrl: BRANCH_STAGE must be 2 (E) or 3 (M)");
    end
    if (REG_AW > REC_AW) begin : g_bad_reg_aw
        $error("pipe_hazard_ctrl: REG_AW exceeds record address width");
    end

    stage_rec_t        rec_e, rec_m, rec_w, dec_rec;
    logic [REC_AW-1:0] rs_x, rt_x;
    logic              load_use, raw_any, hazard;

    assign rs_x = REC_AW'(dec_rs);
    assign rt_x = REC_AW'(dec_rt);

    always_comb begin
        dec_rec          = EMPTY_REC;
        dec_rec.valid    = dec_valid;
        dec_rec.rs       = rs_x;
        dec_rec.rt       = rt_x;
        dec_rec.rd       = REC_AW'(dec_rd);
        dec_rec.regwrite = dec_regwrite && (dec_rd != '0);
        dec_rec.memtoreg = dec_memtoreg;
    end

    assign load_use = dec_valid && rec_e.memtoreg
                      && feeds_decode(rec_e, rs_x, rt_x, dec_uses_rs, dec_uses_rt);
    // Without forwarding the consumer waits until its producer is in W (regfile writes first half).
    assign raw_any  = dec_valid
                      && (feeds_decode(rec_e, rs_x, rt_x, dec_uses_rs, dec_uses_rt)
                          || feeds_decode(rec_m, rs_x, rt_x, dec_uses_rs, dec_uses_rt));
    assign hazard   = (FORWARD_EN != 0) ? load_use : raw_any;

    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        if (mem_busy) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
        end else if (branch_taken) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = (BRANCH_STAGE == BRANCH_M);
        end else if (hazard) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
        end
    end

    assign fwd_a_E = (FORWARD_EN != 0) ? pick_fwd(rec_m, rec_w, rec_e.rs) : FWD_RF;
    assign fwd_b_E = (FORWARD_EN != 0) ? pick_fwd(rec_m, rec_w, rec_e.rt) : FWD_RF;

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_e <= EMPTY_REC;
            rec_m <= EMPTY_REC;
            rec_w <= EMPTY_REC;
        end else if (!mem_busy) begin
            rec_w <= rec_m;
            rec_m <= flush_M ? EMPTY_REC : rec_e;
            rec_e <= (flush_E || stall_D) ? EMPTY_REC : dec_rec;
        end
    end

    logic unused_fields;
    assign unused_fields = ^{rec_m.rs, rec_m.rt, rec_m.memtoreg,
                             rec_w.rs, rec_w.rt, rec_w.memtoreg};

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_D),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_D),
        .count (flush_cnt)
    );

endmodule
